// File: rtl/clock_monitor.sv
// Slow-clock supervisor: measures period and high time of clk_in in clk cycles
// and flags period, duty-cycle and missing-edge faults.
module clock_monitor #(
    parameter int unsigned NOMINAL = 100000000,
    parameter int unsigned TOL     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_in,
    input  logic        clear,
    output logic [31:0] period_cnt,
    output logic [31:0] high_cnt,
    output logic        meas_valid,
    output logic        locked,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [31:0] PER_MIN = 32'(NOMINAL - TOL);
    localparam logic [31:0] PER_MAX = 32'(NOMINAL + TOL);
    localparam logic [31:0] HI_MIN  = 32'(NOMINAL / 2 - TOL);
    localparam logic [31:0] HI_MAX  = 32'(NOMINAL / 2 + TOL);
    localparam logic [31:0] TIMEOUT = 32'(NOMINAL + TOL + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, FAULT} state_t;

    state_t      state, state_nx;
    logic        sync1, sync2, sync3;
    logic [1:0]  warm;
    logic        rise;
    logic [31:0] cyc_cnt, hi_cnt;
    logic [1:0]  code_nx;
    logic        load;
    logic        timeout;

    // warm gates edge detection until sync2/sync3 hold real samples, so a
    // clk_in already high at reset release is not seen as a rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            warm  <= 2'd0;
            rise  <= 1'b0;
        end else begin
            sync1 <= clk_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
            rise <= sync2 & ~sync3 & (warm == 2'd3);
        end
    end

    // sync3 is high on the rise cycle, so the high counter restarts at 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            hi_cnt  <= '0;
        end else if (clear) begin
            cyc_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            cyc_cnt <= 32'd1;
            hi_cnt  <= 32'd1;
        end else begin
            if (cyc_cnt != '1)
                cyc_cnt <= cyc_cnt + 32'd1;
            if (sync3 && hi_cnt != '1)
                hi_cnt <= hi_cnt + 32'd1;
        end
    end

    assign timeout = (cyc_cnt >= TIMEOUT);

    always_comb begin
        state_nx = state;
        code_nx  = fault_code;
        load     = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            code_nx  = 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_nx = MEASURE;
                    end else if (timeout) begin
                        state_nx = FAULT;
                        code_nx  = 2'b10;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        load = 1'b1;
                        if (cyc_cnt < PER_MIN || cyc_cnt > PER_MAX) begin
                            state_nx = FAULT;
                            code_nx  = 2'b01;
                        end else if (hi_cnt < HI_MIN || hi_cnt > HI_MAX) begin
                            state_nx = FAULT;
                            code_nx  = 2'b11;
                        end else begin
                            state_nx = LOCKED;
                        end
                    end else if (timeout) begin
                        state_nx = FAULT;
                        code_nx  = 2'b10;
                    end
                end
                FAULT: ;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fault_code <= 2'b00;
            meas_valid <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            state      <= state_nx;
            fault_code <= code_nx;
            meas_valid <= load;
            if (load) begin
                period_cnt <= cyc_cnt;
                high_cnt   <= hi_cnt;
            end
        end
    end

    assign locked = (state == LOCKED);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor (NOMINAL=100, TOL=2): stimulus pushes the
// expected report and its arrival cycle; the monitor pops on each output event.
module tb_clock_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_in = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] period_cnt, high_cnt;
    logic        meas_valid, locked, fault;
    logic [1:0]  fault_code;

    clock_monitor #(.NOMINAL(100), .TOL(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_in     (clk_in),
        .clear      (clear),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .locked     (locked),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic        mv;
        logic [31:0] per;
        logic [31:0] hi;
        logic        lk;
        logic        ft;
        logic [1:0]  code;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic mv, input int per, input int hi,
                        input logic lk, input logic [1:0] code);
        exp_t e;
        e.at = at; e.mv = mv; e.per = 32'(per); e.hi = 32'(hi);
        e.lk = lk; e.ft = (code != 2'b00); e.code = code;
        q.push_back(e);
    endtask

    // report expected from the rise about to be driven (sampled next edge, seen 3 later)
    task automatic expect_meas(input int per, input int hi, input logic [1:0] code);
        push(cyc + 4, 1'b1, per, hi, code == 2'b00, code);
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] per, input logic [31:0] hi,
                                 input logic lk, input logic ft, input logic [1:0] code);
        cmp({tag, "_period"}, period_cnt, per);
        cmp({tag, "_high"}, high_cnt, hi);
        cmp({tag, "_valid"}, 32'(meas_valid), 32'd0);
        cmp({tag, "_locked"}, 32'(locked), 32'(lk));
        cmp({tag, "_fault"}, 32'(fault), 32'(ft));
        cmp({tag, "_code"}, 32'(fault_code), 32'(code));
    endtask

    // one clk_in period starting with a rise; optional clear on the rise's decision cycle
    task automatic wave(input int per, input int hi, input bit clr,
                        input int keep_per, input int keep_hi);
        clk_in = 1'b1;
        if (clr) begin
            tick(3);
            clear = 1'b1;
            tick(1);
            clear = 1'b0;
            check_outputs("clear", 32'(keep_per), 32'(keep_hi), 1'b0, 1'b0, 2'b00);
            tick(hi - 4);
        end else begin
            tick(hi);
        end
        clk_in = 1'b0;
        tick(per - hi);
    endtask

    logic fault_q = 1'b0;
    logic mv_q = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (mv_q)
                cmp("valid_width", 32'(meas_valid), 32'd0);
            if (meas_valid || (fault && !fault_q)) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output at cycle %0d: valid=%0b fault=%0b code=%0d, expected none",
                             cyc, meas_valid, fault, fault_code);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    cmp("event_cycle", 32'(cyc), 32'(e.at));
                    cmp("meas_valid", 32'(meas_valid), 32'(e.mv));
                    cmp("period_cnt", period_cnt, e.per);
                    cmp("high_cnt", high_cnt, e.hi);
                    cmp("locked", 32'(locked), 32'(e.lk));
                    cmp("fault", 32'(fault), 32'(e.ft));
                    cmp("fault_code", 32'(fault_code), 32'(e.code));
                end
            end
        end
        fault_q = fault;
        mv_q = meas_valid;
    end

    int tc;
    initial begin
        tick(3);
        check_outputs("reset", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        tick(5);

        // lock, then tolerance boundaries, then a long period
        wave(100, 50, 0, 0, 0);
        expect_meas(100, 50, 2'b00); wave(102, 52, 0, 0, 0);
        expect_meas(102, 52, 2'b00); wave(98, 48, 0, 0, 0);
        expect_meas(98, 48, 2'b00);  wave(103, 50, 0, 0, 0);
        expect_meas(103, 50, 2'b01); wave(100, 50, 0, 0, 0);
        wave(100, 50, 0, 0, 0);
        check_outputs("hold", 32'd103, 32'd50, 1'b0, 1'b1, 2'b01);

        // clear on a rise, relock, duty fault
        wave(100, 50, 1, 103, 50);
        wave(100, 50, 0, 0, 0);
        expect_meas(100, 50, 2'b00); wave(100, 60, 0, 0, 0);
        expect_meas(100, 60, 2'b11); wave(97, 60, 0, 0, 0);

        // short period with bad duty reports period fault
        wave(100, 50, 1, 100, 60);
        wave(97, 60, 0, 0, 0);
        expect_meas(97, 60, 2'b01); wave(100, 50, 0, 0, 0);

        // relock, then clk_in stuck low
        wave(100, 50, 1, 97, 60);
        wave(100, 50, 0, 0, 0);
        expect_meas(100, 50, 2'b00); wave(100, 50, 0, 0, 0);
        tc = cyc;
        expect_meas(100, 50, 2'b00); wave(100, 50, 0, 0, 0);
        push(tc + 107, 1'b0, 100, 50, 1'b0, 2'b10);
        tick(20);

        // asynchronous reset mid-period while locked
        wave(100, 50, 1, 100, 50);
        wave(100, 50, 0, 0, 0);
        expect_meas(100, 50, 2'b00);
        clk_in = 1'b1;
        tick(30);
        cmp("locked_before_reset", 32'(locked), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
        tick(3);
        reset = 1'b1;
        tick(20);
        clk_in = 1'b0;
        tick(30);
        wave(100, 50, 0, 0, 0);
        expect_meas(100, 50, 2'b00); wave(100, 50, 0, 0, 0);
        tick(2);

        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_output: expected event at cycle %0d never seen (now %0d)", e.at, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter NOMINAL, 100000000, expected clk_in period in clk cycles (1 Hz at 100 MHz).
REQ-002 SHALL have parameter TOL, 1000, allowed deviation of period and high time, in clk cycles.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port clk_in, input, 1, slow clock under test (e.g. clk_1Hz), asynchronous to clk.
REQ-006 SHALL have port clear, input, 1, synchronous fault clear / restart request.
REQ-007 SHALL have port period_cnt, output, 32, last measured period in clk cycles.
REQ-008 SHALL have port high_cnt, output, 32, last measured high time in clk cycles.
REQ-009 SHALL have port meas_valid, output, 1, one-cycle pulse when period_cnt/high_cnt update.
REQ-010 SHALL have port locked, output, 1, high while the most recent measurement is within tolerance.
REQ-011 SHALL have port fault, output, 1, sticky fault flag.
REQ-012 SHALL have port fault_code, output, 2, 00 none, 01 period out of range, 10 timeout (no edge), 11 duty out of range.

Function
REQ-013 SHALL pass clk_in through a 2-flop synchronizer and detect rising and falling edges on the synchronized signal.
REQ-014 SHALL keep a 32-bit cycle counter: reset to 1 on the cycle of a detected rising edge, +1 otherwise, saturating at 2^32-1.
REQ-015 SHALL keep a 32-bit high counter: cleared on a rising edge, incremented each cycle the synchronized signal is high.
REQ-016 SHALL define period as the cycle counter value on a rising-edge cycle (edges N cycles apart -> period N).
REQ-017 SHALL, on each rising edge except the first after IDLE, register period_cnt and high_cnt and pulse meas_valid for exactly 1 cycle.
REQ-018 SHALL produce the following latency: a clk_in rise sampled at cycle t yields meas_valid, period_cnt, high_cnt, locked and fault updated at cycle t+3.
REQ-019 SHALL implement FSM states IDLE, MEASURE, LOCKED and FAULT.
REQ-020 SHALL transition IDLE -> MEASURE on the first rising edge.
REQ-021 SHALL, in MEASURE or LOCKED on a rising edge, go to FAULT with code 01 if period < NOMINAL-TOL or period > NOMINAL+TOL.
REQ-022 SHALL otherwise go to FAULT with code 11 if high_cnt < NOMINAL/2-TOL or high_cnt > NOMINAL/2+TOL.
REQ-023 SHALL otherwise go to (or stay in) LOCKED.
REQ-024 SHALL give code 01 priority over code 11.
REQ-025 SHALL, in IDLE, MEASURE or LOCKED, go to FAULT with code 10 when the cycle counter reaches NOMINAL+TOL+1 and no rising edge occurs that cycle.
REQ-026 SHALL give a rising edge on the same cycle priority over timeout.
REQ-027 SHALL drive locked = 1 only in state LOCKED and fault = 1 only in state FAULT.
REQ-028 SHALL hold FAULT, fault_code, period_cnt and high_cnt, ignoring edges, until clear.
REQ-029 SHALL, on clear = 1 in any state, go to IDLE next cycle with counters zeroed, fault = 0, fault_code = 00, locked = 0, meas_valid = 0, and period_cnt/high_cnt retained.
REQ-030 SHALL give clear priority over any simultaneous edge or timeout.

Reset
REQ-031 SHALL, while reset = 0 (including mid-operation), immediately force state IDLE, both synchronizer flops 0, all counters 0, period_cnt = 0, high_cnt = 0, meas_valid = 0, locked = 0, fault = 0 and fault_code = 00.
REQ-032 SHALL, after reset release, ignore edges until the synchronizer has sampled clk_in twice; a clk_in already high at release is not a rising edge.

Verification (NOMINAL=100, TOL=2)
REQ-033 SHALL be verified with: square wave, period 100, high 50 -> at second rise +3 cycles meas_valid = 1 for 1 cycle, period_cnt = 100, high_cnt = 50, locked = 1, fault = 0.
REQ-034 SHALL be verified with: after lock, one period of 103 -> fault = 1, fault_code = 01, locked = 0, period_cnt = 103; later edges change nothing.
REQ-035 SHALL be verified with: after lock, clk_in held low -> fault_code = 10 when the counter reaches 103 (103 cycles after the last detected rise), with no meas_valid.
REQ-036 SHALL be verified with: period 100, high 60 -> fault_code = 11, high_cnt = 60; a period of 97 with high 60 -> fault_code = 01.
REQ-037 SHALL be verified with: clear = 1 in FAULT, coinciding with a rising edge -> next cycle IDLE, fault = 0, fault_code = 00; relocks after two further good rises.
REQ-038 SHALL be verified with: reset = 0 mid-period while LOCKED -> all outputs 0 without waiting for clk; after release, first meas_valid only after two new rises.
